// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the packed-BCD datapath
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BCD_MAX  = 9;
    localparam int BCD_BASE = 10;

    typedef logic [3:0] digit_t;

    function automatic logic is_bcd(input digit_t nibble);
        return nibble <= digit_t'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - combinational single-digit BCD subtractor with borrow
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  digit_t x,
    input  digit_t y,
    input  logic   bin,
    output digit_t d,
    output logic   bout
);

    // 5-bit two's complement covers -10..9; bit 4 is the sign and hence the borrow
    logic [4:0] t;
    logic [4:0] tc;

    assign t    = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    assign tc   = t + 5'(BCD_BASE);
    assign bout = t[4];
    assign d    = bout ? tc[3:0] : t[3:0];

endmodule

// File: rtl/bcd_sub_seq.sv
// rtl/bcd_sub_seq.sv - digit-serial |A-B| on packed BCD with separate sign
module bcd_sub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIGITS*4-1:0] A,
    input  logic [DIGITS*4-1:0] B,
    output logic                busy,
    output logic                done,
    output logic [DIGITS*4-1:0] diff,
    output logic                neg,
    output logic                err
);

    localparam int W  = DIGITS * 4;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [IW-1:0]   idx;
    logic            borrow;
    logic            accept;
    logic            operands_ok;
    logic            last;
    digit_t          x;
    digit_t          y;
    digit_t          d;
    logic            bout;

    always_comb begin
        operands_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(A[i*4 +: 4]) || !is_bcd(B[i*4 +: 4])) begin
                operands_ok = 1'b0;
            end
        end
    end

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (idx == LAST);

    // NEG reuses the subtractor as 0 - diff_i to form the ten's complement in place
    always_comb begin
        x = '0;
        y = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                x = (state == SUB) ? a_q[i*4 +: 4] : 4'd0;
                y = (state == SUB) ? b_q[i*4 +: 4] : diff[i*4 +: 4];
            end
        end
    end

    bcd_digit_sub u_digit (
        .x    (x),
        .y    (y),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = operands_ok ? SUB : DONE;
            SUB:  if (last)   state_nx = bout ? NEG : DONE;
            NEG:  if (last)   state_nx = DONE;
            DONE: begin
                if (accept) state_nx = operands_ok ? SUB : DONE;
                else        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SUB) || (state == NEG);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            diff   <= '0;
            neg    <= 1'b0;
            err    <= 1'b0;
            idx    <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_q    <= A;
            b_q    <= B;
            diff   <= '0;
            neg    <= 1'b0;
            err    <= !operands_ok;
            idx    <= '0;
            borrow <= 1'b0;
        end else if (state == SUB || state == NEG) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IW'(i)) begin
                    diff[i*4 +: 4] <= d;
                end
            end
            if (last) begin
                idx    <= '0;
                borrow <= 1'b0;
                if (state == SUB && bout) begin
                    neg <= 1'b1;
                end
            end else begin
                idx    <= idx + 1'b1;
                borrow <= bout;
            end
        end
    end

endmodule

// File: doc/bcd_sub_seq.md
Name: bcd_sub_seq

Overview:
Digit-serial BCD subtractor, the inverse operation to the team's combinational BCD adder.
- Accepts two packed BCD operands on a start strobe.
- Computes |A-B| one digit per cycle using borrow propagation.
- Reports the sign separately.
- Intended for the calculator datapath where area matters more than latency; shares the DIGITS-packed BCD format with the adder.

Parameters:
DIGITS, 4, number of BCD digits per operand/result (≥1); packed width W = DIGITS*4, digit 0 in bits [3:0].

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled on rising clk.
A  input  W  minuend, packed BCD.
B  input  W  subtrahend, packed BCD.
busy  output  1  high while a subtraction is in progress (states SUB, NEG).
done  output  1  one-cycle pulse: result valid.
diff  output  W  |A-B| packed BCD; held until the next accepted start.
neg  output  1  1 when A<B; held with diff.
err  output  1  1 when any input nibble of A or B was >9; held with diff.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, any state): state=IDLE; busy=0, done=0, diff=0, neg=0, err=0; internal borrow, index and operand registers cleared.
- States: IDLE, SUB, NEG, DONE. busy=1 only in SUB and NEG; done=1 only in DONE.
- Start acceptance:
  - start is accepted only in IDLE or DONE. In SUB and NEG it is ignored; no queuing.
  - On accept: latch A and B; clear diff, neg, err, idx and borrow.
  - If any nibble of A or B is >9: set err=1, go to DONE. done is high in the cycle after accept; diff=0, neg=0.
  - Otherwise go to SUB.
- SUB, one edge per digit i = idx:
  - t = A_i - B_i - borrow.
  - If t<0: diff_i = t+10, borrow=1. Else diff_i = t, borrow=0.
  - idx increments.
  - After digit DIGITS-1: if borrow=0, go to DONE; else set neg=1, clear idx and borrow, go to NEG.
- NEG (ten's complement of the partial result), one edge per digit:
  - t = 0 - diff_i - borrow, with the same correction rule as SUB, written back into diff_i.
  - After the last digit, go to DONE. The final borrow is discarded.
- DONE: lasts exactly one cycle, then IDLE. A start in this cycle is accepted and behaves as if from IDLE.
- Latency, with the accept edge as cycle 0:
  - done in cycle DIGITS+1 when A≥B.
  - done in cycle 2*DIGITS+1 when A<B.
  - done in cycle 1 on err.
- Arithmetic rules:
  - The digit datapath is 5-bit signed, range -10..9.
  - Every written diff nibble is in 0..9.
  - A=B yields diff=0, neg=0; never negative zero.
- Operand stability: A and B are only sampled on the accept edge; changes afterwards have no effect.
- Reset mid-operation: the operation is aborted with no done pulse; partial diff is cleared.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, SUB, NEG, DONE);
  - BCD_MAX=9, BCD_BASE=10;
  - digit_t (4-bit) typedef;
  - function is_bcd(nibble).
- Sub-module bcd_digit_sub: combinational single-digit subtractor. Inputs x[3:0], y[3:0], bin; outputs d[3:0], bout. Used in both SUB and NEG, with x=0 in NEG.
- Top bcd_sub_seq contains the FSM, idx counter (clog2(DIGITS) bits), borrow flop, operand/result registers and nibble mux/demux.

Test Plan (DIGITS=4):
- A=5678, B=1234, start → done in cycle 5; diff=4444, neg=0, err=0; busy high in cycles 1-4.
- A=1234, B=5678 → done in cycle 9; diff=4444, neg=1. Also A=0000, B=9999 → diff=9999, neg=1.
- A=1000, B=0001 → diff=0999, neg=0 (borrow ripples through 3 digits). A=B=4321 → diff=0000, neg=0.
- A=12A4, B=0001 → done in cycle 1; err=1, diff=0000, neg=0.
- Second start pulsed during SUB → ignored; result of the first operation unchanged. Start in the DONE cycle with A=0009, B=0010 → accepted; diff=0001, neg=1.
- rst asserted asynchronously mid-NEG → all outputs 0 immediately; no done pulse. A fresh start afterwards completes normally.
